// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU results take priority over buffered memory results,
// with a starvation guard and a pending-write scoreboard for RAW hazard detection.
module wb_write_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_wa,
   input  logic [DATA_W-1:0] alu_wd,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_wa,
   input  logic [DATA_W-1:0] mem_wd,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   input  logic [ADDR_W-1:0] chk_ra1,
   input  logic [ADDR_W-1:0] chk_ra2,
   output logic              pend1,
   output logic              pend2
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);

   logic [ADDR_W-1:0] fifo_wa_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_wa_d [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_wd_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_wd_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
   logic [DATA_W-1:0] rf_wd_q, rf_wd_d;

   logic fifo_empty, starve_hit, alu_fire, push, pop;

   assign fifo_empty = (count_q == '0);
   assign mem_ready  = (count_q != CNT_W'(FIFO_DEPTH));
   assign starve_hit = (starve_q == STV_W'(STARVE_MAX));
   assign alu_ready  = !starve_hit;
   assign alu_fire   = alu_valid && alu_ready;
   // x0 memory writes complete their handshake but never occupy a slot
   assign push       = mem_valid && mem_ready && (mem_wa != '0);
   assign pop        = !alu_fire && !fifo_empty;

   assign rf_we = rf_we_q;
   assign rf_wa = rf_wa_q;
   assign rf_wd = rf_wd_q;

   always_comb begin
      fifo_wa_d = fifo_wa_q;
      fifo_wd_d = fifo_wd_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
      rf_we_d   = 1'b0;
      rf_wa_d   = rf_wa_q;
      rf_wd_d   = rf_wd_q;
      if (push) begin
         fifo_wa_d[wr_ptr_q] = mem_wa;
         fifo_wd_d[wr_ptr_q] = mem_wd;
         wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (alu_fire) begin
         if (alu_wa != '0) begin
            rf_we_d = 1'b1;
            rf_wa_d = alu_wa;
            rf_wd_d = alu_wd;
         end
      end else if (pop) begin
         rf_we_d = 1'b1;
         rf_wa_d = fifo_wa_q[rd_ptr_q];
         rf_wd_d = fifo_wd_q[rd_ptr_q];
      end
      // Counts consecutive ALU wins over a waiting FIFO; a non-empty FIFO without a pop means the ALU won
      starve_d = (fifo_empty || pop) ? '0 : starve_q + 1'b1;
   end

   always_comb begin
      logic [PTR_W-1:0] offs;
      pend1 = rf_we_q && (rf_wa_q == chk_ra1);
      pend2 = rf_we_q && (rf_wa_q == chk_ra2);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         offs = PTR_W'(i) - rd_ptr_q;
         if ({1'b0, offs} < count_q) begin
            if (fifo_wa_q[i] == chk_ra1) pend1 = 1'b1;
            if (fifo_wa_q[i] == chk_ra2) pend2 = 1'b1;
         end
      end
      if (chk_ra1 == '0) pend1 = 1'b0;
      if (chk_ra2 == '0) pend2 = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_wa_q[i] <= '0;
            fifo_wd_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         rf_we_q  <= 1'b0;
         rf_wa_q  <= '0;
         rf_wd_q  <= '0;
      end else begin
         fifo_wa_q <= fifo_wa_d;
         fifo_wd_q <= fifo_wd_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         rf_we_q   <= rf_we_d;
         rf_wa_q   <= rf_wa_d;
         rf_wd_q   <= rf_wd_d;
      end
   end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: stimulus queues expected writes per stream,
// a monitor compares every rf write, and directed checks cover timing, priority and hazards.
module tb_wb_write_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, alu_ready, mem_valid, mem_ready;
   logic [4:0]  alu_wa, mem_wa, rf_wa, chk_ra1, chk_ra2;
   logic [31:0] alu_wd, mem_wd, rf_wd;
   logic        rf_we, pend1, pend2;

   logic [36:0] alu_q[$];
   logic [36:0] mem_q[$];
   int          n_checks = 0;
   int          n_fails  = 0;
   bit          done     = 0;
   int          alu_k, mem_i;

   always #5 clk = ~clk;

   wb_write_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .pend1(pend1), .pend2(pend2)
   );

   task check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task tick;
      @(posedge clk);
      #1;
   endtask

   task monitor;
      logic [36:0] e;
      while (!done) begin
         @(negedge clk);
         if (rst_n && rf_we) begin
            if (alu_q.size() != 0 && alu_q[0][36:32] == rf_wa) begin
               e = alu_q.pop_front();
               check("alu_write", {27'd0, rf_wa, rf_wd}, {27'd0, e});
            end else if (mem_q.size() != 0) begin
               e = mem_q.pop_front();
               check("mem_write", {27'd0, rf_wa, rf_wd}, {27'd0, e});
            end else begin
               check("unexpected_write", {27'd0, rf_wa, rf_wd}, 64'd0);
            end
         end
      end
   endtask

   task idle(input int n);
      alu_valid = 0;
      mem_valid = 0;
      for (int i = 0; i < n; i++) tick;
   endtask

   task stimulus;
      // reset state
      #3;
      check("rst_rf_we", rf_we, 0);
      check("rst_rf_wa", rf_wa, 0);
      check("rst_rf_wd", rf_wd, 0);
      check("rst_mem_ready", mem_ready, 1);
      check("rst_alu_ready", alu_ready, 1);
      check("rst_pend1", pend1, 0);
      check("rst_pend2", pend2, 0);
      #12 rst_n = 1;
      tick;

      // ALU only
      alu_valid = 1; alu_wa = 5; alu_wd = 32'hDEADBEEF;
      alu_q.push_back({5'd5, 32'hDEADBEEF});
      tick;
      alu_valid = 0;
      check("alu_lat_we", rf_we, 1);
      check("alu_lat_wa", rf_wa, 5);
      tick;
      check("alu_one_cycle", rf_we, 0);
      check("alu_idle_hold_wd", rf_wd, 32'hDEADBEEF);
      alu_valid = 1; alu_wa = 0; alu_wd = 32'h123;
      tick;
      alu_valid = 0;
      check("alu_x0_no_we", rf_we, 0);
      idle(2);

      // memory only: r1..r4 back to back, watching r4 in the scoreboard
      chk_ra1 = 4; chk_ra2 = 0;
      for (int i = 1; i <= 4; i++) begin
         mem_valid = 1; mem_wa = 5'(i); mem_wd = 32'h100 + i;
         check("mem_ready_open", mem_ready, 1);
         mem_q.push_back({5'(i), 32'h100 + 32'(i)});
         tick;
      end
      mem_valid = 0;
      check("mem_order_r3", {rf_we, rf_wa}, {1'b1, 5'd3});
      check("mem_pend_queued", pend1, 1);
      tick;
      check("mem_order_r4", {rf_we, rf_wa}, {1'b1, 5'd4});
      check("mem_pend_inflight", pend1, 1);
      tick;
      check("mem_pend_clear", pend1, 0);
      check("mem_drained_we", rf_we, 0);
      idle(2);

      // full FIFO under continuous ALU traffic; starvation pop at c=9
      alu_k = 0; mem_i = 1;
      for (int c = 0; c < 12; c++) begin
         alu_valid = 1; alu_wa = 5'd16 + 5'(alu_k % 8); alu_wd = 32'hA000_0000 + alu_k;
         mem_valid = (mem_i <= 5); mem_wa = 5'(mem_i); mem_wd = 32'h200 + mem_i;
         #1;
         if (c >= 4 && c <= 9) check("full_mem_ready", mem_ready, 0);
         if (c == 10) begin
            check("freed_mem_ready", mem_ready, 1);
            check("full_starve_pop", {rf_we, rf_wa}, {1'b1, 5'd1});
         end
         check("full_alu_ready", alu_ready, (c == 9) ? 1'b0 : 1'b1);
         if (alu_ready) begin
            alu_q.push_back({alu_wa, alu_wd});
            alu_k++;
         end
         if (mem_valid && mem_ready) begin
            mem_q.push_back({mem_wa, mem_wd});
            mem_i++;
         end
         tick;
      end
      check("fifth_accepted", mem_i, 6);
      idle(10);

      // starvation with a single queued entry; ALU payload held across the stall
      alu_k = 0;
      for (int c = 0; c < 12; c++) begin
         alu_valid = 1; alu_wa = 5'd24 + 5'(alu_k % 8); alu_wd = 32'hB000_0000 + alu_k;
         mem_valid = (c == 0); mem_wa = 6; mem_wd = 32'h0600_0006;
         #1;
         check("starve_alu_ready", alu_ready, (c == 9) ? 1'b0 : 1'b1);
         if (c == 10) check("starve_pop_issue", {rf_we, rf_wa}, {1'b1, 5'd6});
         if (c == 11) check("starve_alu_held", {rf_wa, rf_wd}, {5'd25, 32'hB000_0009});
         if (alu_ready) begin
            alu_q.push_back({alu_wa, alu_wd});
            alu_k++;
         end
         if (mem_valid && mem_ready) mem_q.push_back({mem_wa, mem_wd});
         tick;
      end
      idle(4);

      // scoreboard on r7
      chk_ra1 = 7; chk_ra2 = 0;
      mem_valid = 1; mem_wa = 7; mem_wd = 32'h0700_0007;
      mem_q.push_back({5'd7, 32'h0700_0007});
      tick;
      mem_valid = 0;
      check("sb_queued", {pend1, pend2}, 2'b10);
      tick;
      check("sb_inflight", {pend1, pend2, rf_we}, 3'b101);
      tick;
      check("sb_after", {pend1, pend2}, 2'b00);
      idle(2);

      // reset mid-stream with three queued memory writes
      chk_ra1 = 2;
      for (int c = 0; c < 4; c++) begin
         alu_valid = 1;
         alu_wa = (c == 3) ? 5'd17 : 5'd0;
         alu_wd = 32'hC0DE_0017;
         mem_valid = (c < 3); mem_wa = 5'(c + 1); mem_wd = 32'h300 + c;
         if (c == 3) alu_q.push_back({5'd17, 32'hC0DE_0017});
         tick;
      end
      alu_valid = 0; mem_valid = 0;
      check("rst_pre_we", {rf_we, rf_wa}, {1'b1, 5'd17});
      check("rst_pre_pend", pend1, 1);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      check("rst_mid_we", rf_we, 0);
      check("rst_mid_mem_ready", mem_ready, 1);
      check("rst_mid_alu_ready", alu_ready, 1);
      check("rst_mid_pend", pend1, 0);
      #1 rst_n = 1;
      idle(8);
      check("rst_post_pend", pend1, 0);
   endtask

   initial begin
      rst_n = 0; alu_valid = 0; alu_wa = 0; alu_wd = 0;
      mem_valid = 0; mem_wa = 0; mem_wd = 0; chk_ra1 = 3; chk_ra2 = 0;
      fork
         monitor();
         begin
            stimulus();
            done = 1;
         end
      join
      check("alu_q_drained", alu_q.size(), 0);
      check("mem_q_drained", mem_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
